// File: rtl/msg_padder_pkg.sv
// Shared constants and FSM encoding for the message padder.
package msg_padder_pkg;

   localparam logic [7:0] PAD_BYTE        = 8'h80;
   localparam int         WORDS_PER_BLOCK = 16;
   localparam int         IDX_W           = $clog2(WORDS_PER_BLOCK);
   localparam logic [IDX_W-1:0] LEN_POS_HI = IDX_W'(14);
   localparam logic [IDX_W-1:0] LEN_POS_LO = IDX_W'(15);

   // Output-carrying states name the kind of word currently presented:
   // HOLD is a packed message word, PAD/ZERO/LEN_* are generated words.
   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_LOAD   = 3'd1,
      ST_PAD    = 3'd2,
      ST_ZERO   = 3'd3,
      ST_LEN_HI = 3'd4,
      ST_LEN_LO = 3'd5,
      ST_HOLD   = 3'd6
   } state_t;

endpackage

// File: rtl/msg_padder_byte_packer.sv
// Packs bytes MSB-first into a 32-bit word; can close a partial word with
// the pad byte followed by zeros.
module byte_packer
   import msg_padder_pkg::*;
(
   input  logic        i_clk,
   input  logic        i_reset,
   input  logic [7:0]  i_byte,
   input  logic        i_push,
   input  logic        i_flush_pad,
   output logic [31:0] o_word,
   output logic [1:0]  o_fill,
   output logic        o_done
);

   logic [31:0] r_buf;
   logic [1:0]  r_fill;
   logic [31:0] w_byte_sh;
   logic [31:0] w_pad_sh;

   // Merge the incoming byte (and the pad byte after it) into the buffer.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no latch is inferred.
      w_pad_sh  = '0;
      w_byte_sh = {i_byte, 24'h0} >> {r_fill, 3'b000};
      if (i_flush_pad && (r_fill != 2'd3)) begin
         w_pad_sh = {PAD_BYTE, 24'h0} >> ({r_fill, 3'b000} + 5'd8);
      end
      o_word = r_buf | w_byte_sh | w_pad_sh;
      o_done = i_push && ((r_fill == 2'd3) || i_flush_pad);
   end

   assign o_fill = r_fill;

   // Buffer and fill count; a completed word leaves the buffer empty.
   always_ff @(posedge i_clk) begin
      // NOTE: sequential state uses non-blocking assignments only.
      if (i_reset) begin
         r_buf  <= '0;
         r_fill <= '0;
      end else if (i_push) begin
         if (o_done) begin
            r_buf  <= '0;
            r_fill <= '0;
         end else begin
            r_buf  <= r_buf | w_byte_sh;
            r_fill <= r_fill + 2'd1;
         end
      end
   end

endmodule

// File: rtl/msg_padder.sv
// Message padder: turns a byte stream into 512-bit blocks of big-endian
// 32-bit words with 0x80 pad, zero fill and a 64-bit bit-length trailer.
module msg_padder
   import msg_padder_pkg::*;
#(
   parameter int LEN_W = 64
) (
   input  logic             i_clk,
   input  logic             i_reset,
   input  logic [7:0]       i_din,
   input  logic             i_din_valid,
   input  logic             i_din_last,
   output logic             o_din_ready,
   input  logic             i_empty_msg,
   output logic [31:0]      o_w_out,
   output logic             o_w_valid,
   input  logic             i_w_ready,
   output logic [IDX_W-1:0] o_i,
   output logic             o_blk_start,
   output logic             o_msg_done
);

   state_t            r_state, w_state;
   logic [IDX_W-1:0]  r_i, w_i;
   logic [31:0]       r_w_out, w_w_out;
   logic [LEN_W-1:0]  r_cnt, w_cnt;
   logic              r_pad_due, w_pad_due;   // held word is a full last word
   logic              r_padded, w_padded;     // pad byte already emitted
   logic              r_len_ok, w_len_ok;     // length fits in current block

   logic              w_accept;
   logic              w_push;
   logic              w_fire;
   logic [IDX_W-1:0]  w_next_i;
   logic [63:0]       w_len;
   logic [31:0]       w_pk_word;
   logic [1:0]        w_pk_fill;
   logic              w_pk_done;

   assign w_accept    = (r_state == ST_IDLE) || (r_state == ST_LOAD);
   assign o_din_ready = w_accept && !i_reset;
   assign w_push      = i_din_valid && o_din_ready;
   assign o_w_valid   = (r_state == ST_HOLD) || (r_state == ST_PAD) ||
                        (r_state == ST_ZERO) || (r_state == ST_LEN_HI) ||
                        (r_state == ST_LEN_LO);
   assign w_fire      = o_w_valid && i_w_ready;
   assign w_next_i    = r_i + IDX_W'(1);
   assign w_len       = 64'(r_cnt);

   assign o_w_out     = r_w_out;
   assign o_i         = r_i;
   assign o_blk_start = o_w_valid && (r_i == '0);
   assign o_msg_done  = (r_state == ST_LEN_LO);

   byte_packer u_packer (
      .i_clk       (i_clk),
      .i_reset     (i_reset),
      .i_byte      (i_din),
      .i_push      (w_push),
      .i_flush_pad (i_din_last),
      .o_word      (w_pk_word),
      .o_fill      (w_pk_fill),
      .o_done      (w_pk_done)
   );

   // Next-state and next-word selection.
   always_comb begin
      w_state   = r_state;
      w_i       = r_i;
      w_w_out   = r_w_out;
      w_cnt     = r_cnt;
      w_pad_due = r_pad_due;
      w_padded  = r_padded;
      w_len_ok  = r_len_ok;

      if (w_push) begin
         w_cnt = r_cnt + LEN_W'(8);
      end

      case (r_state)
         ST_IDLE, ST_LOAD: begin
            if (w_push) begin
               if (w_pk_done) begin
                  w_state   = ST_HOLD;
                  w_w_out   = w_pk_word;
                  w_padded  = i_din_last && (w_pk_fill != 2'd3);
                  w_pad_due = i_din_last && (w_pk_fill == 2'd3);
                  w_len_ok  = (r_i < LEN_POS_HI);
               end else begin
                  w_state = ST_LOAD;
               end
            end else if ((r_state == ST_IDLE) && i_empty_msg) begin
               w_state  = ST_PAD;
               w_w_out  = {PAD_BYTE, 24'h0};
               w_i      = '0;
               w_padded = 1'b1;
               w_len_ok = 1'b1;
            end
         end

         ST_HOLD, ST_PAD, ST_ZERO: begin
            if (w_fire) begin
               w_i = w_next_i;
               if ((r_state == ST_HOLD) && !r_padded) begin
                  if (r_pad_due) begin
                     w_state  = ST_PAD;
                     w_w_out  = {PAD_BYTE, 24'h0};
                     w_padded = 1'b1;
                     w_len_ok = (w_next_i < LEN_POS_HI);
                  end else begin
                     w_state = ST_LOAD;
                  end
               end else begin
                  // Pad already out: zero fill until the length slot.
                  w_w_out = '0;
                  w_state = ST_ZERO;
                  if (w_next_i == '0) begin
                     w_len_ok = 1'b1;
                  end else if ((w_next_i == LEN_POS_HI) && r_len_ok) begin
                     w_state = ST_LEN_HI;
                     w_w_out = w_len[63:32];
                  end
               end
            end
         end

         ST_LEN_HI: begin
            if (w_fire) begin
               w_i     = LEN_POS_LO;
               w_state = ST_LEN_LO;
               w_w_out = w_len[31:0];
            end
         end

         ST_LEN_LO: begin
            if (w_fire) begin
               w_state   = ST_IDLE;
               w_i       = '0;
               w_cnt     = '0;
               w_pad_due = 1'b0;
               w_padded  = 1'b0;
               w_len_ok  = 1'b0;
            end
         end

         default: begin
            w_state = ST_IDLE;
         end
      endcase
   end

   // State, index, output word and bit counter registers.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state   <= ST_IDLE;
         r_i       <= '0;
         r_w_out   <= '0;
         r_cnt     <= '0;
         r_pad_due <= 1'b0;
         r_padded  <= 1'b0;
         r_len_ok  <= 1'b0;
      end else begin
         r_state   <= w_state;
         r_i       <= w_i;
         r_w_out   <= w_w_out;
         r_cnt     <= w_cnt;
         r_pad_due <= w_pad_due;
         r_padded  <= w_padded;
         r_len_ok  <= w_len_ok;
      end
   end

endmodule

// File: doc/msg_padder.md
MSG_PADDER -- requirements
Module: msg_padder

Interface
REQ-001 Parameter LEN_W, default 64, SHALL set the width of the message bit-length counter and the length field appended by padding.
REQ-002 Port CLK, input, 1, SHALL be the single clock; all state updates on posedge CLK.
REQ-003 Port RESET, input, 1, SHALL be the reset, synchronous and active-high.
REQ-004 Port DIN, input, 8, SHALL carry a message byte, first byte first.
REQ-005 Port DIN_VALID, input, 1, SHALL qualify DIN.
REQ-006 Port DIN_LAST, input, 1, SHALL mark the final message byte; it is sampled only with DIN_VALID.
REQ-007 Port DIN_READY, output, 1, SHALL indicate a byte is accepted this cycle when DIN_VALID=1.
REQ-008 Port EMPTY_MSG, input, 1, SHALL be a one-cycle pulse in IDLE that requests padding of a zero-length message.
REQ-009 Port W_OUT, output, 32, SHALL carry a big-endian schedule word for the compressor W_IN.
REQ-010 Port W_VALID / W_READY, output / input, 1 each, SHALL form the word handshake; a transfer occurs when both are high.
REQ-011 Port I, output, 4, SHALL give the word index 0..15 within the current block.
REQ-012 Port BLK_START, output, 1, SHALL be high with word 0 of every block.
REQ-013 Port MSG_DONE, output, 1, SHALL be high with word 15 of the final block.

Function
REQ-014 The FSM SHALL have the states IDLE, LOAD, PAD, ZERO, LEN_HI, LEN_LO and HOLD.
- HOLD means an output word is pending.
REQ-015 In LOAD, bytes SHALL be packed MSB-first into a 32-bit word; the fourth byte completes the word and enters HOLD.
REQ-016 DIN_READY SHALL be 1 only in IDLE or LOAD while no output word is pending.
- Throughput is one byte per cycle.
REQ-017 The bit counter SHALL increment by 8 per accepted byte, modulo 2^LEN_W.
REQ-018 The byte accepted with DIN_LAST SHALL trigger PAD, which completes the current word with 0x80 followed by zero bytes.
- If the last byte fills the word, PAD SHALL emit a full word 0x80000000.
REQ-019 After PAD, ZERO SHALL emit 0x00000000 words up to and including index 13; LEN_HI then emits counter[63:32] at I=14, and LEN_LO emits counter[31:0] at I=15.
REQ-020 If the 0x80 word lands at I=14 or I=15, the block SHALL be zero-filled through I=15, and a second block of zeros I=0..13 plus the length at I=14..15 SHALL follow.
REQ-021 An EMPTY_MSG pulse SHALL produce one block: 0x80000000, 14 zero words, then length 0.
REQ-022 W_OUT, I, BLK_START and MSG_DONE SHALL be held stable while W_VALID=1 and W_READY=0.
REQ-023 The first word SHALL appear on W_VALID exactly 1 cycle after the byte (or PAD event) that completes it.
- Every subsequent generated word SHALL follow 1 cycle after the previous transfer.
REQ-024 After the LEN_LO transfer, the FSM SHALL return to IDLE and clear the counter; W_VALID SHALL be 0 in IDLE.
REQ-025 In any state other than IDLE, EMPTY_MSG SHALL be ignored.
- DIN_VALID=1 with DIN_LAST=1 in IDLE SHALL start a 1-byte message.

Reset
REQ-026 While RESET=1, the FSM SHALL be in IDLE and the counter, I and the pack buffer SHALL be 0.
- W_OUT=0, W_VALID=0, BLK_START=0, MSG_DONE=0 and DIN_READY=0.
- RESET SHALL abort any message in progress, and no further words of it SHALL be emitted.
REQ-027 DIN_READY SHALL become 1 on the first cycle after RESET deasserts.

Structure
REQ-028 A shared header SHALL hold the FSM state encodings, PAD_BYTE=8'h80, WORDS_PER_BLOCK=16 and LEN_POS_HI=14.
REQ-029 Byte-to-word packing SHALL be a sub-module byte_packer (8-bit in, 32-bit out, fill count, flush-with-pad input).

Verification
REQ-030 "abc" (0x61,0x62,0x63 with LAST) -> 0x61626380, 13 zeros, then 0x00000000 and 0x00000018; MSG_DONE is high on I=15.
REQ-031 A 55-byte message -> one block whose I=13 word ends in 0x80, with I=15 = 0x000001B8.
REQ-032 A 56-byte message -> two blocks; block 2 is 14 zeros then 0x00000000 and 0x000001C0, and BLK_START is high twice.
REQ-033 EMPTY_MSG pulse -> 0x80000000, 14 zeros, then 0x00000000; the final word is 0x00000000 with MSG_DONE=1.
REQ-034 "abc" with W_READY toggling 1-0-0-1 on each word -> identical word sequence, and outputs are stable during every stall.
REQ-035 RESET asserted after word 5 of a 64-byte message -> all outputs reach reset values the next cycle, and a following "abc" produces REQ-030 output.
